// File: rtl/cnn_stream_pkg.sv
// rtl/cnn_stream_pkg.sv - shared types and helpers for the padded pixel streamer
package cnn_stream_pkg;

    localparam int PIXEL_W = 16;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pad_state_e;

    // Side length of the padded output frame.
    function automatic int out_size(input int img_w, input int pad);
        return img_w + 2 * pad;
    endfunction

endpackage

// File: rtl/pad_stream_gen_if.sv
// rtl/pad_stream_gen_if.sv - RAM read port and pixel stream bundle (PAD_STREAM_SIDEBAND_EN adds eol/eof)
interface pad_stream_gen_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);

    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_rdata;
    logic signed [DATA_W-1:0] pixel_out;
    logic                     valid_out;
    logic                     ready_in;
`ifdef PAD_STREAM_SIDEBAND_EN
    logic                     eol_out;
    logic                     eof_out;
`endif

    modport master (
        output mem_rd_en,
        output mem_addr,
        output pixel_out,
        output valid_out,
`ifdef PAD_STREAM_SIDEBAND_EN
        output eol_out,
        output eof_out,
`endif
        input  mem_rdata,
        input  ready_in
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        input  pixel_out,
        input  valid_out,
`ifdef PAD_STREAM_SIDEBAND_EN
        input  eol_out,
        input  eof_out,
`endif
        output mem_rdata,
        output ready_in
    );

endinterface

// File: rtl/pad_skid_fifo.sv
// rtl/pad_skid_fifo.sv - 2-deep FIFO holding issued pixels ahead of the output port
module pad_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // The issue credit keeps push-while-full from happening; guards are defensive only.
    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && (count != 2'd2);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; clear empties the FIFO and zeroes entries.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pad_stream_gen.sv
// rtl/pad_stream_gen.sv - zero-padded raster streamer from RAM; PAD_STREAM_SIDEBAND_EN adds eol/eof outputs
module pad_stream_gen
    import cnn_stream_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int PAD    = 1,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    pad_stream_gen_if.master bus
);

    localparam int OUT   = out_size(IMG_W, PAD);
    localparam int CNT_W = $clog2(OUT + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT - 1);
    localparam logic [CNT_W-1:0] PAD_LO   = CNT_W'(PAD);
    localparam logic [CNT_W-1:0] PAD_HI   = CNT_W'(IMG_W + PAD);

`ifdef PAD_STREAM_SIDEBAND_EN
    localparam int ENTRY_W = DATA_W + 2;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    pad_state_e          state_q;
    pad_state_e          state_d;
    logic [CNT_W-1:0]    row;
    logic [CNT_W-1:0]    col;
    logic [ADDR_W-1:0]   addr_cnt;
    logic                stg_valid;
    logic                stg_pad;
    logic [1:0]          fifo_count;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [ENTRY_W-1:0]  push_data;
    logic [DATA_W-1:0]   stg_pixel;
    logic [2:0]          occupancy;
    logic                pos_pad;
    logic                last_pos;
    logic                can_issue;
    logic                issue;
    logic                pop;
    logic                valid;
    logic                frame_start;
    logic                drain_done;

    generate
        if (PAD == 0) begin : g_no_pad
            assign pos_pad = 1'b0;
        end else begin : g_pad
            assign pos_pad = (row < PAD_LO) || (row >= PAD_HI) ||
                             (col < PAD_LO) || (col >= PAD_HI);
        end
    endgenerate

    assign last_pos    = (row == LAST_IDX) && (col == LAST_IDX);
    assign valid       = (fifo_count != 2'd0);
    assign pop         = valid && bus.ready_in;
    assign frame_start = (state_q == IDLE) && start;

    // Credit counts the entry leaving this cycle, so a full-rate stream keeps one
    // pixel in the FIFO and one in flight. This puts ready_in on the mem_rd_en path.
    assign occupancy = {1'b0, fifo_count} + {2'b0, stg_valid};
    assign can_issue = (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);
    assign issue     = (state_q == RUN) && can_issue;

    assign drain_done = pop && (fifo_count == 2'd1) && !stg_valid;

    assign bus.mem_rd_en = issue && !pos_pad;
    assign bus.mem_addr  = addr_cnt;

    // Frame sequencing state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue && last_pos) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Raster position and RAM address counters; address advances only on interior reads.
    always_ff @(posedge clk) begin
        if (!reset || frame_start) begin
            row      <= '0;
            col      <= '0;
            addr_cnt <= '0;
        end else if (issue) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
            if (!pos_pad) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    // One-cycle stage matching RAM latency; pad positions ride along as tagged zeros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_valid <= 1'b0;
            stg_pad   <= 1'b0;
        end else begin
            stg_valid <= issue;
            stg_pad   <= pos_pad;
        end
    end

    assign stg_pixel = stg_pad ? '0 : bus.mem_rdata;

`ifdef PAD_STREAM_SIDEBAND_EN
    logic stg_eol;
    logic stg_eof;

    // Row/frame end markers captured alongside the issued position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_eol <= 1'b0;
            stg_eof <= 1'b0;
        end else begin
            stg_eol <= (col == LAST_IDX);
            stg_eof <= last_pos;
        end
    end

    assign push_data   = {stg_eof, stg_eol, stg_pixel};
    assign bus.eol_out = valid && fifo_head[DATA_W];
    assign bus.eof_out = valid && fifo_head[DATA_W+1];
`else
    assign push_data = stg_pixel;
`endif

    pad_skid_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .clear_n   (reset),
        .push      (stg_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign bus.valid_out = valid;
    assign bus.pixel_out = valid ? fifo_head[DATA_W-1:0] : '0;

endmodule
